yadmc_spram_port: RTL and testbench

Access controller that acts as the sole initiator of one single-port synchronous RAM (one-cycle read latency). It accepts a write request channel and a read request channel from client logic, arbitrates them onto the single RAM port one access per cycle, and returns read data on a valid/ready response channel. A small response buffer absorbs the RAM's fixed read latency under back-pressure. It sits between YADMC-side client logic (prefetch/write buffers) and a RAM instance.

---
 rtl/yadmc_spram_port_pkg.sv | 17 +
 rtl/yadmc_spram.sv | 25 ++
 rtl/yadmc_spram_port_fifo.sv | 47 ++++
 rtl/yadmc_spram_port.sv | 101 ++++++++++
 tb/tb_yadmc_spram_port.sv | 385 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/yadmc_spram_port_pkg.sv
// Shared types for the yadmc single-port RAM access controller.
package yadmc_spram_port_pkg;

    localparam int unsigned RD_CREDITS = 2;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_WR,
        GNT_RD
    } grant_e;

    typedef enum logic {
        LAST_WR = 1'b0,
        LAST_RD = 1'b1
    } last_e;

endpackage

// File: rtl/yadmc_spram.sv
// Single-port synchronous RAM with one-cycle registered read.
module yadmc_spram #(
    parameter int address_depth = 10,
    parameter int data_width    = 8
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [address_depth-1:0] adr,
    input  logic [data_width-1:0]    di,
    output logic [data_width-1:0]    dout
);

    logic [data_width-1:0] mem_q [2**address_depth];
    logic [data_width-1:0] dout_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[adr] <= di;
        end
        dout_q <= mem_q[adr];
    end

    assign dout = dout_q;

endmodule

// File: rtl/yadmc_spram_port_fifo.sv
// Two-entry response FIFO that absorbs the RAM read latency under back-pressure.
module yadmc_spram_port_fifo #(
    parameter int data_width = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic [data_width-1:0] din,
    output logic [data_width-1:0] head,
    output logic [1:0]            count
);

    logic [data_width-1:0] mem_q [2];
    logic                  wr_ptr_q, wr_ptr_d;
    logic                  rd_ptr_q, rd_ptr_d;
    logic [1:0]            count_q, count_d;

    always_comb begin
        wr_ptr_d = push ? ~wr_ptr_q : wr_ptr_q;
        rd_ptr_d = pop ? ~rd_ptr_q : rd_ptr_q;
        count_d  = count_q + {1'b0, push} - {1'b0, pop};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; count gates visibility.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/yadmc_spram_port.sv
// Arbitrates write and read clients onto one RAM port; returns
// read data through a credit-limited response FIFO.
module yadmc_spram_port
    import yadmc_spram_port_pkg::*;
#(
    parameter int address_depth = 10,
    parameter int data_width    = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_stb,
    input  logic [address_depth-1:0] wr_adr,
    input  logic [data_width-1:0]    wr_dat,
    output logic                     wr_ack,
    input  logic                     rd_stb,
    input  logic [address_depth-1:0] rd_adr,
    output logic                     rd_ack,
    output logic                     rd_valid,
    output logic [data_width-1:0]    rd_dat,
    input  logic                     rd_ready,
    output logic [address_depth-1:0] mem_adr,
    output logic                     mem_we,
    output logic [data_width-1:0]    mem_di,
    input  logic [data_width-1:0]    mem_do
);

    last_e  last_q, last_d;
    logic   inflight_q, inflight_d;
    grant_e gnt;
    logic   pop;
    logic   rd_elig;
    logic [1:0] count;
    logic [2:0] occ;

    assign pop = rd_valid & rd_ready;
    // Outstanding reads after this cycle's pop must leave room for one more.
    assign occ = {1'b0, count} + {2'b0, inflight_q} - {2'b0, pop};
    assign rd_elig = rd_stb & (occ < 3'(RD_CREDITS));

    always_comb begin
        gnt    = GNT_NONE;
        last_d = last_q;
        if (!rst) begin
            if (wr_stb && rd_elig) begin
                gnt    = (last_q == LAST_RD) ? GNT_WR : GNT_RD;
                last_d = (last_q == LAST_RD) ? LAST_WR : LAST_RD;
            end else if (wr_stb) begin
                gnt = GNT_WR;
            end else if (rd_elig) begin
                gnt = GNT_RD;
            end
        end
    end

    always_comb begin
        wr_ack  = 1'b0;
        rd_ack  = 1'b0;
        mem_we  = 1'b0;
        mem_adr = '0;
        mem_di  = '0;
        unique case (gnt)
            GNT_WR: begin
                wr_ack  = 1'b1;
                mem_we  = 1'b1;
                mem_adr = wr_adr;
                mem_di  = wr_dat;
            end
            GNT_RD: begin
                rd_ack  = 1'b1;
                mem_adr = rd_adr;
            end
            default: ;
        endcase
        inflight_d = (gnt == GNT_RD);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q     <= LAST_RD;
            inflight_q <= 1'b0;
        end else begin
            last_q     <= last_d;
            inflight_q <= inflight_d;
        end
    end

    yadmc_spram_port_fifo #(
        .data_width (data_width)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (inflight_q),
        .pop   (pop),
        .din   (mem_do),
        .head  (rd_dat),
        .count (count)
    );

    assign rd_valid = (count != 2'd0);

endmodule

// File: tb/tb_yadmc_spram_port.sv
// Randomized bench for yadmc_spram_port against a transaction-level model.
module tb_yadmc_spram_port;

    localparam int AW = 10;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_stb;
    logic [AW-1:0] wr_adr;
    logic [DW-1:0] wr_dat;
    logic          wr_ack;
    logic          rd_stb;
    logic [AW-1:0] rd_adr;
    logic          rd_ack;
    logic          rd_valid;
    logic [DW-1:0] rd_dat;
    logic          rd_ready;
    logic [AW-1:0] mem_adr;
    logic          mem_we;
    logic [DW-1:0] mem_di;
    logic [DW-1:0] mem_do;

    always #5 clk = ~clk;

    yadmc_spram_port #(
        .address_depth (AW),
        .data_width    (DW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_stb   (wr_stb),
        .wr_adr   (wr_adr),
        .wr_dat   (wr_dat),
        .wr_ack   (wr_ack),
        .rd_stb   (rd_stb),
        .rd_adr   (rd_adr),
        .rd_ack   (rd_ack),
        .rd_valid (rd_valid),
        .rd_dat   (rd_dat),
        .rd_ready (rd_ready),
        .mem_adr  (mem_adr),
        .mem_we   (mem_we),
        .mem_di   (mem_di),
        .mem_do   (mem_do)
    );

    yadmc_spram #(
        .address_depth (AW),
        .data_width    (DW)
    ) u_ram (
        .clk  (clk),
        .we   (mem_we),
        .adr  (mem_adr),
        .di   (mem_di),
        .dout (mem_do)
    );

    typedef struct {
        logic [DW-1:0] data;
        int            rdy;
    } resp_t;

    int            vectors    = 0;
    int            miscompares = 0;
    int            cyc        = 0;
    logic [DW-1:0] ref_mem [1024];
    resp_t         pend[$];
    bit            prefer_wr  = 1'b1;
    bit            exp_wr, exp_rd;
    logic          obs_wr_ack, obs_rd_ack, obs_valid;
    logic [DW-1:0] obs_dat;
    int            obs_pops   = 0;

    // One clock of the model: outstanding reads become visible two cycles
    // after acceptance, at most two may be outstanding, contention alternates.
    task automatic step();
        bit            ev, pop, rel, ew, er;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        @(negedge clk);
        ev  = (pend.size() > 0) && (pend[0].rdy <= cyc);
        pop = ev && !rst && rd_ready;
        ew  = 1'b0;
        er  = 1'b0;
        if (!rst) begin
            rel = rd_stb && ((pend.size() - int'(pop)) < 2);
            if (wr_stb && rel) begin
                if (prefer_wr) ew = 1'b1;
                else er = 1'b1;
                prefer_wr = !prefer_wr;
            end else begin
                ew = wr_stb;
                er = rel;
            end
        end
        ea = ew ? wr_adr : (er ? rd_adr : '0);
        ed = ew ? wr_dat : '0;
        obs_wr_ack = wr_ack;
        obs_rd_ack = rd_ack;
        obs_valid  = rd_valid;
        obs_dat    = rd_dat;
        if (rd_valid === 1'b1 && rd_ready && !rst) obs_pops++;
        vectors += 6;
        if (wr_ack !== ew) begin
            miscompares++;
            $display("FAIL wr_ack cyc=%0d got=%b exp=%b", cyc, wr_ack, ew);
        end
        if (rd_ack !== er) begin
            miscompares++;
            $display("FAIL rd_ack cyc=%0d got=%b exp=%b", cyc, rd_ack, er);
        end
        if (mem_we !== ew) begin
            miscompares++;
            $display("FAIL mem_we cyc=%0d got=%b exp=%b", cyc, mem_we, ew);
        end
        if (mem_adr !== ea) begin
            miscompares++;
            $display("FAIL mem_adr cyc=%0d got=%h exp=%h", cyc, mem_adr, ea);
        end
        if (mem_di !== ed) begin
            miscompares++;
            $display("FAIL mem_di cyc=%0d got=%h exp=%h", cyc, mem_di, ed);
        end
        if (rd_valid !== ev) begin
            miscompares++;
            $display("FAIL rd_valid cyc=%0d got=%b exp=%b", cyc, rd_valid, ev);
        end
        if (ev) begin
            vectors++;
            if (rd_dat !== pend[0].data) begin
                miscompares++;
                $display("FAIL rd_dat cyc=%0d got=%h exp=%h",
                         cyc, rd_dat, pend[0].data);
            end
        end
        if (rst) begin
            pend.delete();
            prefer_wr = 1'b1;
        end else begin
            if (pop) void'(pend.pop_front());
            if (ew) ref_mem[wr_adr] = wr_dat;
            if (er) pend.push_back('{data: ref_mem[rd_adr], rdy: cyc + 2});
        end
        exp_wr = ew;
        exp_rd = er;
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        rd_stb   = 1'b0;
        wr_stb   = 1'b0;
        rd_ready = 1'b1;
        for (int i = 0; i < 8 && pend.size() > 0; i++) step();
        step();
    endtask

    task automatic test_reset();
        rst    = 1'b1;
        wr_stb = 1'b1;
        wr_adr = 10'h003;
        wr_dat = 8'h33;
        rd_stb = 1'b1;
        rd_adr = 10'h003;
        rd_ready = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            step();
            vectors++;
            if (obs_wr_ack !== 1'b0 || obs_rd_ack !== 1'b0 || obs_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_quiet got=%b%b%b exp=000",
                         obs_wr_ack, obs_rd_ack, obs_valid);
            end
        end
        rst = 1'b0;
        step();
        vectors++;
        if (obs_wr_ack !== 1'b1 || obs_rd_ack !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_first_winner got=%b%b exp=10", obs_wr_ack, obs_rd_ack);
        end
        wr_stb = 1'b0;
        step();
        rd_stb = 1'b0;
        drain();
    endtask

    task automatic test_write_read();
        wr_stb = 1'b1;
        wr_adr = 10'h012;
        wr_dat = 8'hA5;
        step();
        wr_stb = 1'b0;
        rd_stb = 1'b1;
        rd_adr = 10'h012;
        step();
        vectors++;
        if (obs_rd_ack !== 1'b1) begin
            miscompares++;
            $display("FAIL wr_rd_ack got=%b exp=1", obs_rd_ack);
        end
        rd_stb = 1'b0;
        step();
        vectors++;
        if (obs_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL wr_rd_early got=%b exp=0", obs_valid);
        end
        step();
        vectors++;
        if (obs_valid !== 1'b1 || obs_dat !== 8'hA5) begin
            miscompares++;
            $display("FAIL wr_rd_latency got=%b/%h exp=1/a5", obs_valid, obs_dat);
        end
        drain();
    endtask

    task automatic test_streaming();
        int acks = 0;
        int idx  = 0;
        int pops0;
        for (int i = 0; i < 16; i++) begin
            wr_stb = 1'b1;
            wr_adr = AW'(i);
            wr_dat = DW'(i);
            step();
        end
        wr_stb   = 1'b0;
        rd_ready = 1'b1;
        pops0    = obs_pops;
        for (int k = 0; k < 16; k++) begin
            rd_stb = 1'b1;
            rd_adr = AW'(idx);
            step();
            if (obs_rd_ack === 1'b1) acks++;
            if (exp_rd) idx++;
        end
        rd_stb = 1'b0;
        step();
        step();
        vectors += 2;
        if (acks != 16) begin
            miscompares++;
            $display("FAIL stream_acks got=%0d exp=16", acks);
        end
        if (obs_pops - pops0 != 16) begin
            miscompares++;
            $display("FAIL stream_words got=%0d exp=16", obs_pops - pops0);
        end
        drain();
    endtask

    task automatic test_back_pressure();
        int acks = 0;
        rd_ready = 1'b0;
        rd_stb   = 1'b1;
        rd_adr   = AW'($urandom_range(0, 15));
        for (int k = 0; k < 6; k++) begin
            step();
            if (obs_rd_ack === 1'b1) acks++;
            if (exp_rd) rd_adr = AW'($urandom_range(0, 15));
        end
        vectors++;
        if (acks != 2) begin
            miscompares++;
            $display("FAIL bp_acks got=%0d exp=2", acks);
        end
        rd_ready = 1'b1;
        acks = 0;
        for (int k = 0; k < 6; k++) begin
            step();
            if (obs_rd_ack === 1'b1) acks++;
            if (exp_rd) rd_adr = AW'($urandom_range(0, 15));
        end
        vectors++;
        if (acks == 0) begin
            miscompares++;
            $display("FAIL bp_resume got=%0d exp=>0", acks);
        end
        drain();
        vectors++;
        if (obs_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_drained got=%b exp=0", obs_valid);
        end
    endtask

    task automatic test_contention();
        logic [AW-1:0] last_w;
        rst = 1'b1;
        step();
        rst      = 1'b0;
        rd_ready = 1'b1;
        wr_stb   = 1'b1;
        wr_adr   = 10'h100;
        wr_dat   = DW'($urandom);
        rd_stb   = 1'b1;
        rd_adr   = 10'h012;
        last_w   = 10'h012;
        for (int k = 0; k < 8; k++) begin
            step();
            vectors++;
            if (obs_wr_ack !== ((k % 2) == 0) || obs_rd_ack !== ((k % 2) == 1)) begin
                miscompares++;
                $display("FAIL contention_order k=%0d got=%b%b exp=%b%b", k,
                         obs_wr_ack, obs_rd_ack, (k % 2) == 0, (k % 2) == 1);
            end
            if (exp_wr) begin
                last_w = wr_adr;
                wr_adr = wr_adr + 1'b1;
                wr_dat = DW'($urandom);
            end
            if (exp_rd) rd_adr = last_w;
        end
        drain();
    endtask

    task automatic test_reset_mid();
        rd_ready = 1'b1;
        rd_stb   = 1'b1;
        rd_adr   = 10'h005;
        step();
        rd_stb = 1'b0;
        rst    = 1'b1;
        step();
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            vectors++;
            if (obs_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL rstmid_ghost k=%0d got=%b exp=0", k, obs_valid);
            end
        end
        rd_stb = 1'b1;
        rd_adr = 10'h007;
        step();
        rd_stb = 1'b0;
        step();
        step();
        vectors++;
        if (obs_valid !== 1'b1 || obs_dat !== 8'h07) begin
            miscompares++;
            $display("FAIL rstmid_read got=%b/%h exp=1/07", obs_valid, obs_dat);
        end
        drain();
    endtask

    task automatic test_random();
        wr_stb = 1'b0;
        rd_stb = 1'b0;
        for (int k = 0; k < 400; k++) begin
            if (!wr_stb || exp_wr) begin
                wr_stb = 1'($urandom_range(0, 1));
                wr_adr = AW'($urandom_range(0, 15));
                wr_dat = DW'($urandom);
            end
            if (!rd_stb || exp_rd) begin
                rd_stb = 1'($urandom_range(0, 1));
                rd_adr = AW'($urandom_range(0, 15));
            end
            rd_ready = ($urandom_range(0, 3) != 0);
            step();
            exp_wr = exp_wr;
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_streaming();
        test_back_pressure();
        test_contention();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
